// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl
//   Playback sequencer between the board switches and the audio datapath.
//   Synchronizes and debounces the prev/next/pause/filter switches, runs the
//   STOP/LOAD/PLAY/PAUSE track FSM with a load_req/load_ack handshake to the
//   sample reader, and counts elapsed mm:ss onto four seven-segment exports.
//
// Build option:
//   AUDIO_PLAYBACK_LOOP_ALL_EN  defined   -> track selection wraps around and
//                                            playback loops over all tracks.
//                              undefined -> track selection saturates, and
//                                            track_end on the last track stops.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   anterior_sw    raw previous-track switch (async)
//   siguiente_sw   raw next-track switch (async)
//   pausa_sw       raw play/pause switch (async)
//   filt_sw[3:0]   raw filter switches (async)
//   track_end      1-cycle pulse: current track exhausted
//   load_ack       sample reader accepted load_req
//   load_req       request to (re)load track_idx from its start
//   track_idx      current track index
//   play_en        audio datapath runs when high
//   filter_en      any debounced filter switch on
//   filter_sel     lowest-numbered active filter switch
//   seg1_export    seconds ones digit   (active-low gfedcba)
//   seg2_export    seconds tens digit
//   min1_export    minutes ones digit
//   min2_export    minutes tens digit
module audio_playback_ctrl #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned DEB_CYC   = 500000,
  parameter int unsigned N_TRACKS  = 8,
  parameter int unsigned TRK_W     = 3,
  parameter int unsigned RESTART_S = 3
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             anterior_sw,
  input  logic             siguiente_sw,
  input  logic             pausa_sw,
  input  logic [3:0]       filt_sw,
  input  logic             track_end,
  input  logic             load_ack,
  output logic             load_req,
  output logic [TRK_W-1:0] track_idx,
  output logic             play_en,
  output logic             filter_en,
  output logic [1:0]       filter_sel,
  output logic [6:0]       seg1_export,
  output logic [6:0]       seg2_export,
  output logic [6:0]       min1_export,
  output logic [6:0]       min2_export
);

`ifdef AUDIO_PLAYBACK_LOOP_ALL_EN
  localparam bit LOOP_ALL = 1'b1;
`else
  localparam bit LOOP_ALL = 1'b0;
`endif

  localparam int unsigned NSW = 7;
  localparam int unsigned DW  = $clog2(DEB_CYC + 1);
  localparam int unsigned PW  = $clog2(CLK_HZ + 1);

  typedef enum logic [1:0] {STOP, LOAD, PLAY, PAUSE} state_t;

  // bit 0 prev, 1 next, 2 pause, 6:3 filters
  logic [NSW-1:0] raw_sw, sync1, sync2, deb, deb_d;
  logic [DW-1:0]  deb_cnt [NSW];
  logic           ev_prev, ev_next, ev_pause;

  state_t           state, state_nxt;
  logic [TRK_W-1:0] trk_nxt, idx_next, idx_prev;
  logic             last_trk, restart;

  logic [PW-1:0] presc;
  logic [3:0]    sec_ones, sec_tens, min_ones, min_tens;
  logic [6:0]    sec_val;
  logic          at_max;

  assign raw_sw = {filt_sw, pausa_sw, siguiente_sw, anterior_sw};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < NSW; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw_sw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < NSW; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign ev_prev  = deb[0] & ~deb_d[0];
  assign ev_next  = deb[1] & ~deb_d[1];
  assign ev_pause = deb[2] & ~deb_d[2];

  assign filter_en = |deb[6:3];
  always_comb begin
    filter_sel = 2'd0;
    if      (deb[3]) filter_sel = 2'd0;
    else if (deb[4]) filter_sel = 2'd1;
    else if (deb[5]) filter_sel = 2'd2;
    else if (deb[6]) filter_sel = 2'd3;
  end

  assign last_trk = (track_idx == TRK_W'(N_TRACKS - 1));
  assign idx_next = last_trk ? (LOOP_ALL ? '0 : track_idx) : track_idx + TRK_W'(1);
  assign idx_prev = (track_idx == '0) ? (LOOP_ALL ? TRK_W'(N_TRACKS - 1) : '0)
                                      : track_idx - TRK_W'(1);

  assign sec_val = 7'(sec_tens) * 7'd10 + 7'(sec_ones);
  assign restart = (min_tens != 4'd0) || (min_ones != 4'd0) || (32'(sec_val) >= RESTART_S);

  always_comb begin
    state_nxt = state;
    trk_nxt   = track_idx;
    case (state)
      STOP: begin
        if (ev_prev)       trk_nxt   = idx_prev;
        else if (ev_next)  trk_nxt   = idx_next;
        else if (ev_pause) state_nxt = LOAD;
      end
      LOAD: begin
        if (load_ack) state_nxt = PLAY;
      end
      PLAY, PAUSE: begin
        if (ev_prev) begin
          state_nxt = LOAD;
          trk_nxt   = restart ? track_idx : idx_prev;
        end else if (ev_next) begin
          state_nxt = LOAD;
          trk_nxt   = idx_next;
        end else if (ev_pause) begin
          state_nxt = (state == PLAY) ? PAUSE : PLAY;
        end else if (track_end && state == PLAY) begin
          if (last_trk && !LOOP_ALL) begin
            state_nxt = STOP;
          end else begin
            state_nxt = LOAD;
            trk_nxt   = idx_next;
          end
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= STOP;
      track_idx <= '0;
    end else begin
      state     <= state_nxt;
      track_idx <= trk_nxt;
    end
  end

  assign load_req = (state == LOAD);
  assign play_en  = (state == PLAY);

  assign at_max = (min_tens == 4'd9) && (min_ones == 4'd9) &&
                  (sec_tens == 4'd5) && (sec_ones == 4'd9);

  // Clearing keys off state_nxt so the counters already read 00:00 in the
  // first LOAD cycle; the prescaler only moves in PLAY, so PAUSE holds it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc    <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else if (state_nxt == LOAD) begin
      presc    <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else if (state == PLAY) begin
      if (presc == PW'(CLK_HZ - 1)) begin
        presc <= '0;
        if (!at_max) begin
          if (sec_ones != 4'd9) begin
            sec_ones <= sec_ones + 4'd1;
          end else begin
            sec_ones <= '0;
            if (sec_tens != 4'd5) begin
              sec_tens <= sec_tens + 4'd1;
            end else begin
              sec_tens <= '0;
              if (min_ones != 4'd9) begin
                min_ones <= min_ones + 4'd1;
              end else begin
                min_ones <= '0;
                min_tens <= min_tens + 4'd1;
              end
            end
          end
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      seg1_export <= 7'b1000000;
      seg2_export <= 7'b1000000;
      min1_export <= 7'b1000000;
      min2_export <= 7'b1000000;
    end else begin
      seg1_export <= seg7(sec_ones);
      seg2_export <= seg7(sec_tens);
      min1_export <= seg7(min_ones);
      min2_export <= seg7(min_tens);
    end
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Self-checking bench for audio_playback_ctrl. Expected track indices are
// queued when a switch event is driven and compared when load_req rises;
// elapsed time is checked against a count of completed PLAY cycles.
module tb_audio_playback_ctrl;
  localparam int unsigned CLK_HZ    = 10;
  localparam int unsigned DEB_CYC   = 4;
  localparam int unsigned N_TRACKS  = 4;
  localparam int unsigned TRK_W     = 2;
  localparam int unsigned RESTART_S = 3;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n = 1'b0;
  logic             anterior_sw = 1'b0, siguiente_sw = 1'b0, pausa_sw = 1'b0;
  logic [3:0]       filt_sw = 4'd0;
  logic             track_end = 1'b0, load_ack = 1'b0;
  logic             load_req, play_en, filter_en;
  logic [TRK_W-1:0] track_idx;
  logic [1:0]       filter_sel;
  logic [6:0]       seg1_export, seg2_export, min1_export, min2_export;

  audio_playback_ctrl #(
    .CLK_HZ(CLK_HZ), .DEB_CYC(DEB_CYC), .N_TRACKS(N_TRACKS),
    .TRK_W(TRK_W), .RESTART_S(RESTART_S)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .anterior_sw(anterior_sw), .siguiente_sw(siguiente_sw), .pausa_sw(pausa_sw),
    .filt_sw(filt_sw), .track_end(track_end), .load_ack(load_ack),
    .load_req(load_req), .track_idx(track_idx), .play_en(play_en),
    .filter_en(filter_en), .filter_sel(filter_sel),
    .seg1_export(seg1_export), .seg2_export(seg2_export),
    .min1_export(min1_export), .min2_export(min2_export)
  );

  always #5 clk_clk = ~clk_clk;

  int unsigned n_vec = 0, n_err = 0;
  logic [TRK_W-1:0] exp_q [$];
  int unsigned k = 0, k_prev = 0, disp_k = 0;
  bit lr_prev = 1'b0;

`ifdef AUDIO_PLAYBACK_LOOP_ALL_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int unsigned d);
    case (d)
      0: enc = 7'b1000000; 1: enc = 7'b1111001; 2: enc = 7'b0100100;
      3: enc = 7'b0110000; 4: enc = 7'b0011001; 5: enc = 7'b0010010;
      6: enc = 7'b0000010; 7: enc = 7'b1111000; 8: enc = 7'b0000000;
      9: enc = 7'b0010000; default: enc = 7'b1111111;
    endcase
  endfunction

  // Scoreboard pop on load_req rise, and elapsed-time model
  initial forever begin
    @(negedge clk_clk);
    if (!reset_reset_n) begin
      k = 0; k_prev = 0; disp_k = 0; lr_prev = 1'b0;
    end else begin
      if (load_req && !lr_prev) begin
        if (exp_q.size() == 0) check("unexpected_load", 32'(track_idx), 32'hFFFF);
        else check("load_idx", 32'(track_idx), 32'(exp_q.pop_front()));
      end
      lr_prev = load_req;
      if (load_req) k = 0;
      disp_k = k_prev;
      k_prev = k;
      if (play_en) k++;
    end
  end

  // Sample reader: ack two cycles into a request
  initial begin : ack_proc
    int unsigned cnt;
    cnt = 0;
    forever begin
      @(posedge clk_clk); #1;
      if (load_req) begin
        cnt++;
        load_ack = (cnt == 2);
      end else begin
        cnt = 0;
        load_ack = 1'b0;
      end
    end
  end

  task automatic sync_n();
    @(negedge clk_clk); #1;
  endtask

  task automatic check_time(input string tag);
    int unsigned s;
    s = disp_k / CLK_HZ;
    if (s > 5999) s = 5999;
    check({tag, "_s1"}, 32'(seg1_export), 32'(enc(s % 10)));
    check({tag, "_s2"}, 32'(seg2_export), 32'(enc((s / 10) % 6)));
    check({tag, "_m1"}, 32'(min1_export), 32'(enc((s / 60) % 10)));
    check({tag, "_m2"}, 32'(min2_export), 32'(enc(s / 600)));
  endtask

  task automatic wait_play(input logic want, input int unsigned budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (play_en === want) begin ok = 1'b1; break; end
      sync_n();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_load(input int unsigned budget, output int unsigned lat);
    lat = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk_clk);
      lat++;
      if (load_req) break;
    end
  endtask

  task automatic wait_sec(input int unsigned target, input int unsigned budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      sync_n();
      if (disp_k / CLK_HZ == target) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic set_sw(input int unsigned which, input logic v);
    case (which)
      0: anterior_sw = v;
      1: siguiente_sw = v;
      default: pausa_sw = v;
    endcase
  endtask

  task automatic press(input int unsigned which, input int unsigned hold);
    @(posedge clk_clk); #1 set_sw(which, 1'b1);
    repeat (hold) @(posedge clk_clk);
    #1 set_sw(which, 1'b0);
    repeat (10) @(posedge clk_clk);
    sync_n();
  endtask

  initial begin
    int unsigned lat;
    logic [3:0] fv [5];
    logic [1:0] fs [5];
    logic       fe [5];
    fv = '{4'b1010, 4'b1000, 4'b0100, 4'b0111, 4'b0000};
    fs = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    fe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk_clk);
    sync_n();
    check("rst_load_req", 32'(load_req), 32'd0);
    check("rst_track", 32'(track_idx), 32'd0);
    check("rst_play", 32'(play_en), 32'd0);
    check("rst_filt_en", 32'(filter_en), 32'd0);
    check("rst_filt_sel", 32'(filter_sel), 32'd0);
    check_time("rst");
    @(posedge clk_clk); #1 reset_reset_n = 1'b1;

    // First play: load latency, then 00:10 after 100 play cycles
    exp_q.push_back(2'd0);
    @(posedge clk_clk); #1 pausa_sw = 1'b1;
    wait_load(20, lat);
    check("load_latency", lat, 32'd8);
    sync_n();
    wait_play(1'b1, 10, "play_start");
    pausa_sw = 1'b0;
    repeat (102) sync_n();
    check_time("t10");
    check("t10_seg1", 32'(seg1_export), 32'h40);
    check("t10_seg2", 32'(seg2_export), 32'h79);

    // Bounce too short to register
    @(posedge clk_clk); #1 pausa_sw = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1 pausa_sw = 1'b0;
    repeat (12) sync_n();
    check("bounce_play", 32'(play_en), 32'd1);
    check_time("t_bounce");

    // Pause freezes, resume keeps the prescaler
    press(2, 8);
    check("paused", 32'(play_en), 32'd0);
    check_time("t_pause0");
    repeat (50) sync_n();
    check_time("t_pause50");
    press(2, 8);
    check("resumed", 32'(play_en), 32'd1);
    repeat (23) sync_n();
    check_time("t_resume");

    // Restart vs. step back
    exp_q.push_back(2'd1); press(1, 8);
    exp_q.push_back(2'd2); press(1, 8);
    wait_play(1'b1, 10, "play_trk2");
    wait_sec(5, 200, "reach_5s");
    exp_q.push_back(2'd2); press(0, 8);
    check("restart_seg1", 32'(seg1_export), 32'h40);
    check_time("t_restart");
    wait_sec(1, 100, "reach_1s");
    exp_q.push_back(2'd1); press(0, 8);
    check("prev_trk", 32'(track_idx), 32'd1);

    // Last track behaviour
    exp_q.push_back(2'd2); press(1, 8);
    exp_q.push_back(2'd3); press(1, 8);
    exp_q.push_back(LOOP ? 2'd0 : 2'd3); press(1, 8);
    check("next_at_last", 32'(track_idx), LOOP ? 32'd0 : 32'd3);
    if (LOOP) begin
      exp_q.push_back(2'd3); press(0, 8);
      check("prev_wrap", 32'(track_idx), 32'd3);
      exp_q.push_back(2'd0);
    end
    @(posedge clk_clk); #1 track_end = 1'b1;
    @(posedge clk_clk); #1 track_end = 1'b0;
    repeat (8) sync_n();
    if (LOOP) begin
      check("end_loop_trk", 32'(track_idx), 32'd0);
      check("end_loop_play", 32'(play_en), 32'd1);
      exp_q.push_back(2'd1); press(1, 8);
    end else begin
      check("end_stop_play", 32'(play_en), 32'd0);
      check("end_stop_trk", 32'(track_idx), 32'd3);
      check_time("t_stop");
      repeat (20) sync_n();
      check_time("t_stop_hold");
      press(0, 8);
      check("stop_prev1", 32'(track_idx), 32'd2);
      press(0, 8);
      check("stop_prev2", 32'(track_idx), 32'd1);
      exp_q.push_back(2'd1); press(2, 8);
    end
    check("on_trk1", 32'(track_idx), 32'd1);

    // ev_next and track_end in the same cycle
    exp_q.push_back(2'd2);
    @(posedge clk_clk); #1 siguiente_sw = 1'b1;
    repeat (6) @(posedge clk_clk);
    #1 track_end = 1'b1;
    @(posedge clk_clk); #1 track_end = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1 siguiente_sw = 1'b0;
    repeat (12) sync_n();
    check("simul_trk", 32'(track_idx), 32'd2);
    check("simul_play", 32'(play_en), 32'd1);

    // Filter priority
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk_clk); #1 filt_sw = fv[i];
      repeat (10) sync_n();
      check("filter_en", 32'(filter_en), 32'(fe[i]));
      check("filter_sel", 32'(filter_sel), 32'(fs[i]));
    end

    // Saturation at 99:59
    repeat (60300) sync_n();
    check_time("t_sat");
    check("sat_seg1", 32'(seg1_export), 32'h10);
    check("sat_seg2", 32'(seg2_export), 32'h12);
    check("sat_min1", 32'(min1_export), 32'h10);
    check("sat_min2", 32'(min2_export), 32'h10);

    // Asynchronous reset in LOAD
    exp_q.push_back(2'd3);
    @(posedge clk_clk); #1 siguiente_sw = 1'b1;
    wait_load(20, lat);
    check("load_seen", 32'(load_req), 32'd1);
    #2 reset_reset_n = 1'b0;
    #1;
    check("arst_load_req", 32'(load_req), 32'd0);
    check("arst_seg1", 32'(seg1_export), 32'h40);
    check("arst_seg2", 32'(seg2_export), 32'h40);
    check("arst_min1", 32'(min1_export), 32'h40);
    check("arst_min2", 32'(min2_export), 32'h40);
    check("arst_trk", 32'(track_idx), 32'd0);
    siguiente_sw = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    repeat (12) sync_n();
    check("post_rst_stop", 32'(load_req), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/audio_playback_ctrl.md
Name: audio_playback_ctrl

Overview:
- Playback sequencer between the board switches and the audio datapath (sample reader, filter bank, DAC path).
- Debounces the prev/next/pause/filter switches, runs the track-selection state machine and issues track-load requests to the sample reader with a req/ack handshake.
- Gates playback and counts elapsed mm:ss, driving the four seven-segment exports.

Parameters:
- CLK_HZ, 50000000, clk_clk cycles per elapsed-time second.
- DEB_CYC, 500000, cycles a raw switch must stay stable before its debounced level changes.
- N_TRACKS, 8, number of tracks (>=2).
- TRK_W, 3, width of track index; must satisfy 2^TRK_W >= N_TRACKS.
- RESTART_S, 3, elapsed seconds at or above which "anterior" restarts the current track instead of stepping back.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- anterior_sw  in  1  raw previous-track switch, active high, asynchronous to clk.
- siguiente_sw  in  1  raw next-track switch, active high.
- pausa_sw  in  1  raw play/pause switch, active high.
- filt_sw  in  4  raw filter switches [3:0].
- track_end  in  1  one-cycle pulse from sample reader: current track exhausted.
- load_ack  in  1  sample reader accepted load_req.
- load_req  out  1  request to (re)load track_idx from its start.
- track_idx  out  TRK_W  current track index.
- play_en  out  1  audio datapath runs when high.
- filter_en  out  1  any filter switch on.
- filter_sel  out  2  index of lowest-numbered active filter switch.
- seg1_export  out  7  seconds ones digit.
- seg2_export  out  7  seconds tens digit.
- min1_export  out  7  minutes ones digit.
- min2_export  out  7  minutes tens digit.

Behaviour:
- Inputs: every raw switch passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synced input differs from it for DEB_CYC consecutive cycles. A rising edge of the debounced level gives a 1-cycle event (ev_prev, ev_next, ev_pause).
- Filter outputs: filter_en and filter_sel are combinational from the debounced filt levels. Priority is bit0 > bit1 > bit2 > bit3; filter_sel = 0 when none are set.
- FSM states: STOP, LOAD, PLAY, PAUSE. Reset goes to STOP with track_idx=0, time=00:00, load_req=0, play_en=0, filter_en=0, filter_sel=0.
- STOP:
  - ev_pause -> LOAD (same track_idx).
  - ev_next/ev_prev update track_idx per the index rules below and stay in STOP.
- LOAD:
  - Clears time and the second prescaler on entry.
  - load_req=1 every cycle until a cycle with load_ack=1; the next cycle is PLAY and load_req=0.
  - All events and track_end are ignored in LOAD.
- PLAY:
  - play_en=1.
  - The prescaler counts 0..CLK_HZ-1; its wrap produces a one-second tick.
  - ev_pause -> PAUSE.
  - ev_next -> LOAD with next index.
  - ev_prev -> LOAD: same index if elapsed seconds >= RESTART_S, else previous index.
  - track_end -> LOAD with next index. At the last track without wrap, track_end -> STOP with track_idx unchanged and time held.
- PAUSE:
  - play_en=0; prescaler and time frozen.
  - ev_pause -> PLAY with the prescaler resuming from its held value.
  - ev_next/ev_prev behave as in PLAY (playback resumes after LOAD).
- Simultaneous events in one cycle: ev_prev > ev_next > ev_pause > track_end. Lower-priority events that cycle are dropped.
- Index rules (no wrap): next saturates at N_TRACKS-1; prev saturates at 0.
- Time:
  - BCD sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-9.
  - Ripple carry on tick. At 99:59 the count saturates.
- Seven-seg:
  - Active-low; bit6..bit0 = g,f,e,d,c,b,a.
  - Registered from the BCD digits, so displays lag the counters by 1 cycle.
  - Reset value 7'b1000000 ("0") on all four.
- Reset asserted mid-LOAD drops load_req immediately (asynchronous).

Optional Feature:
- Macro: AUDIO_PLAYBACK_LOOP_ALL_EN.
- When defined: next from N_TRACKS-1 wraps to 0; prev from 0 (under RESTART_S) wraps to N_TRACKS-1; track_end at the last track -> LOAD track 0 (continuous loop, never enters STOP from PLAY).
- When undefined: the saturating rules above apply.

Test Plan (CLK_HZ=10, DEB_CYC=4, N_TRACKS=4, RESTART_S=3, load_ack returned 2 cycles after load_req):
- Reset, then pausa_sw pulse held 8 cycles -> load_req rises ~7 cycles after the edge, track_idx=0; PLAY follows the ack. After 100 cycles the displays show 00:10, seg1_export=7'b1000000, seg2_export=7'b1111001.
- pausa_sw held only 2 cycles (bounce) -> no event, state unchanged. A second press in PLAY -> play_en=0 and time frozen for 50 cycles; a third press resumes with no lost prescaler count.
- At 00:05 on track 2, anterior_sw -> LOAD track 2 and time 00:00. At 00:01, anterior_sw -> LOAD track 1.
- On track 3, siguiente_sw -> track_idx stays 3 (undefined macro) or becomes 0 (macro defined). track_end on track 3 -> STOP (undefined) or LOAD track 0 (defined).
- ev_next and track_end in the same cycle on track 1 -> single LOAD to track 2, not 3. filt_sw=4'b1010 -> filter_en=1, filter_sel=1.
- Force time to 99:58 and run 30 ticks -> display holds 99:59. Assert reset_reset_n=0 during LOAD -> load_req=0 and all seg exports read "0" in the same cycle.
